// File: rtl/fifo_wptr_burst.sv
// Write-side pointer controller for a dual-clock FIFO with multi-entry bursts.
// Keeps the binary and Gray write pointers and registered level/space/flag outputs.
module fifo_wptr_burst #(
    parameter int POINTER_WIDTH = 5,
    parameter int MAX_WR        = 4,
    parameter int CW            = $clog2(MAX_WR + 1)
) (
    input  logic                       w_clk,
    input  logic                       wrst,
    input  logic                       wr_vld,
    input  logic [CW-1:0]              wr_cnt,
    input  logic [POINTER_WIDTH-1:0]   gray_rptr,
    input  logic [POINTER_WIDTH-1:0]   af_thresh,
    input  logic                       ovf_clr,
    output logic                       wr_acc,
    output logic [CW-1:0]              wr_acc_cnt,
    output logic [POINTER_WIDTH-2:0]   waddr,
    output logic [POINTER_WIDTH-1:0]   gray_wptr,
    output logic [POINTER_WIDTH-1:0]   wlevel,
    output logic [POINTER_WIDTH-1:0]   wspace,
    output logic                       wfull,
    output logic                       walmost_full,
    output logic                       wovf
);

    localparam logic [POINTER_WIDTH-1:0] DEPTH = POINTER_WIDTH'(1) << (POINTER_WIDTH - 1);

    logic [POINTER_WIDTH-1:0] wptr_q,         wptr_d;
    logic [POINTER_WIDTH-1:0] gray_wptr_q,    gray_wptr_d;
    logic [POINTER_WIDTH-1:0] wlevel_q,       wlevel_d;
    logic [POINTER_WIDTH-1:0] wspace_q,       wspace_d;
    logic                     wfull_q,        wfull_d;
    logic                     walmost_full_q, walmost_full_d;
    logic                     wovf_q,         wovf_d;

    logic [POINTER_WIDTH-1:0] rptr_bin;
    logic [POINTER_WIDTH-1:0] wr_cnt_ext;
    logic                     req_nz;
    logic                     wr_rej;

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < POINTER_WIDTH; gi++) begin : g_g2b
            assign rptr_bin[gi] = ^gray_rptr[POINTER_WIDTH-1:gi];
        end
    endgenerate

    // Acceptance only looks at last cycle's registered space, never at gray_rptr.
    always_comb begin
        wr_cnt_ext = POINTER_WIDTH'(wr_cnt);
        req_nz     = !wrst && wr_vld && (wr_cnt != '0);
        wr_acc     = req_nz && (wr_cnt_ext <= wspace_q);
        wr_rej     = req_nz && (wr_cnt_ext > wspace_q);
        wr_acc_cnt = wr_acc ? wr_cnt : '0;
    end

    always_comb begin
        wptr_d         = wr_acc ? (wptr_q + wr_cnt_ext) : wptr_q;
        gray_wptr_d    = wptr_d ^ (wptr_d >> 1);
        wlevel_d       = wptr_d - rptr_bin;
        wspace_d       = DEPTH - wlevel_d;
        wfull_d        = (wlevel_d == DEPTH);
        walmost_full_d = (wlevel_d >= af_thresh);
        // A reject in the same cycle as a clear keeps the flag set.
        if (wr_rej) begin
            wovf_d = 1'b1;
        end else if (ovf_clr) begin
            wovf_d = 1'b0;
        end else begin
            wovf_d = wovf_q;
        end
    end

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            wptr_q         <= '0;
            gray_wptr_q    <= '0;
            wlevel_q       <= '0;
            wspace_q       <= DEPTH;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wovf_q         <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            gray_wptr_q    <= gray_wptr_d;
            wlevel_q       <= wlevel_d;
            wspace_q       <= wspace_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wovf_q         <= wovf_d;
        end
    end

    assign waddr        = wptr_q[POINTER_WIDTH-2:0];
    assign gray_wptr    = gray_wptr_q;
    assign wlevel       = wlevel_q;
    assign wspace       = wspace_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wovf         = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_burst.sv
// Randomised and directed bench for fifo_wptr_burst against a running-total model
// of entries written and read.
module tb_fifo_wptr_burst;

    localparam int PW     = 5;
    localparam int MAX_WR = 4;
    localparam int CW     = 3;
    localparam int DEPTH  = 16;

    logic          w_clk = 1'b0;
    logic          wrst;
    logic          wr_vld;
    logic [CW-1:0] wr_cnt;
    logic [PW-1:0] gray_rptr;
    logic [PW-1:0] af_thresh;
    logic          ovf_clr;
    logic          wr_acc;
    logic [CW-1:0] wr_acc_cnt;
    logic [PW-2:0] waddr;
    logic [PW-1:0] gray_wptr;
    logic [PW-1:0] wlevel;
    logic [PW-1:0] wspace;
    logic          wfull;
    logic          walmost_full;
    logic          wovf;

    fifo_wptr_burst #(
        .POINTER_WIDTH(PW),
        .MAX_WR       (MAX_WR),
        .CW           (CW)
    ) dut (
        .w_clk       (w_clk),
        .wrst        (wrst),
        .wr_vld      (wr_vld),
        .wr_cnt      (wr_cnt),
        .gray_rptr   (gray_rptr),
        .af_thresh   (af_thresh),
        .ovf_clr     (ovf_clr),
        .wr_acc      (wr_acc),
        .wr_acc_cnt  (wr_acc_cnt),
        .waddr       (waddr),
        .gray_wptr   (gray_wptr),
        .wlevel      (wlevel),
        .wspace      (wspace),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wovf        (wovf)
    );

    always #5 w_clk = ~w_clk;

    // Model: total entries ever written / read since reset, plus registered flags.
    int m_w, m_r, m_lvl;
    bit m_ovf, m_alm, m_full;
    int n_cmp, n_bad;

    function automatic logic [PW-1:0] bin2gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b % 32);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one cycle starting just after a falling edge, checks the
    // combinational accept, then the registered outputs after the rising edge.
    task automatic cycle(input bit rst, input bit vld, input int cnt, input int rd,
                         input bit clr, input int af);
        bit exp_acc, rej;
        wrst      = rst;
        wr_vld    = vld;
        wr_cnt    = cnt[CW-1:0];
        ovf_clr   = clr;
        af_thresh = af[PW-1:0];
        if (rst) m_r = 0;
        else     m_r += rd;
        gray_rptr = bin2gray(m_r);
        exp_acc = !rst && vld && (cnt != 0) && (cnt <= DEPTH - m_lvl);
        #1;
        chk("wr_acc", wr_acc, exp_acc);
        chk("wr_acc_cnt", wr_acc_cnt, exp_acc ? cnt : 0);
        @(posedge w_clk);
        if (rst) begin
            m_w = 0; m_lvl = 0; m_ovf = 0; m_alm = 0; m_full = 0;
        end else begin
            rej = vld && (cnt != 0) && !exp_acc;
            if (exp_acc) m_w += cnt;
            if (rej)      m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_lvl  = m_w - m_r;
            m_full = (m_lvl == DEPTH);
            m_alm  = (m_lvl >= af);
        end
        #1;
        chk("waddr", waddr, m_w % DEPTH);
        chk("gray_wptr", gray_wptr, bin2gray(m_w));
        chk("wlevel", wlevel, m_lvl);
        chk("wspace", wspace, DEPTH - m_lvl);
        chk("wfull", wfull, m_full);
        chk("walmost_full", walmost_full, m_alm);
        chk("wovf", wovf, m_ovf);
        $display("t=%0t rst=%0d vld=%0d cnt=%0d rd=%0d acc=%0d lvl=%0d ovf=%0d",
                 $time, rst, vld, cnt, m_r, exp_acc, m_lvl, m_ovf);
        @(negedge w_clk);
    endtask

    always @(posedge w_clk) begin
        if (!wrst && wr_vld)
            assert (wr_cnt <= MAX_WR) else $error("illegal wr_cnt %0d", wr_cnt);
        if (wrst === 1'b0)
            assert (wlevel <= DEPTH) else $error("level %0d exceeds depth", wlevel);
    end

    initial begin
        int af, rd, cnt;
        n_cmp = 0; n_bad = 0;
        m_w = 0; m_r = 0; m_lvl = 0; m_ovf = 0; m_alm = 0; m_full = 0;
        wrst = 1; wr_vld = 0; wr_cnt = 0; gray_rptr = 0; af_thresh = 0; ovf_clr = 0;
        @(negedge w_clk);

        // Reset with a request pending: dropped, not flagged
        cycle(1, 1, 3, 0, 0, 12);
        cycle(1, 1, 3, 0, 0, 12);
        chk("rst_wspace", wspace, 16);
        chk("rst_wovf", wovf, 0);

        // Fill with four bursts of four
        for (int i = 0; i < 4; i++) begin
            chk("fill_waddr", waddr, 4 * i);
            cycle(0, 1, 4, 0, 0, 12);
            chk("fill_wlevel", wlevel, 4 * (i + 1));
        end
        chk("fill_wfull", wfull, 1);
        chk("fill_gray", gray_wptr, 5'b11000);

        // Overflow while full, then clear racing another reject
        cycle(0, 1, 1, 0, 0, 12);
        chk("ovf_set", wovf, 1);
        chk("ovf_gray_hold", gray_wptr, 5'b11000);
        cycle(0, 1, 1, 0, 1, 12);
        chk("ovf_set_wins", wovf, 1);
        cycle(0, 0, 0, 0, 1, 12);
        chk("ovf_cleared", wovf, 0);

        // Partial room: level 14, burst of 3 rejected, burst of 2 fits
        cycle(0, 0, 0, 2, 0, 12);
        chk("part_lvl", wlevel, 14);
        cycle(0, 1, 3, 0, 0, 12);
        chk("part_rej_ovf", wovf, 1);
        cycle(0, 1, 2, 0, 1, 12);
        chk("part_acc_lvl", wlevel, 16);

        // Wrap across the address end: wptr 14, rptr 10, burst of 4
        cycle(1, 0, 0, 0, 0, 12);
        cycle(0, 1, 4, 0, 0, 12);
        cycle(0, 1, 4, 0, 0, 12);
        cycle(0, 1, 4, 4, 0, 12);
        cycle(0, 1, 2, 4, 0, 12);
        cycle(0, 0, 0, 2, 0, 12);
        chk("wrap_waddr0", waddr, 14);
        chk("wrap_lvl0", wlevel, 4);
        cycle(0, 1, 4, 0, 0, 12);
        chk("wrap_waddr", waddr, 2);
        chk("wrap_lvl", wlevel, 8);
        chk("wrap_gray", gray_wptr, 5'b11011);

        // Threshold and read progress
        cycle(0, 1, 4, 0, 0, 12);
        chk("af_on", walmost_full, 1);
        cycle(0, 0, 0, 3, 0, 12);
        chk("af_off", walmost_full, 0);
        chk("af_lvl", wlevel, 9);
        chk("af_space", wspace, 7);
        cycle(0, 0, 0, 0, 0, 0);
        chk("af_zero", walmost_full, 1);
        cycle(0, 1, 4, 0, 0, 20);
        cycle(0, 1, 3, 0, 0, 20);
        chk("af_above_depth", walmost_full, 0);
        chk("af_full", wfull, 1);

        // Randomised traffic
        af = 12;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) af = $urandom_range(0, 20);
            rd = $urandom_range(0, 3);
            if (rd > m_w - m_r) rd = m_w - m_r;
            cnt = $urandom_range(0, MAX_WR);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, cnt, rd,
                  $urandom_range(0, 7) == 0, af);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
